psram_arbiter: RTL and testbench

PSRAM_ARBITER -- requirements
Module: psram_arbiter

---
 rtl/psram_pkg.sv | 34 +++
 rtl/psram_arbiter_rr_arb2.sv | 18 +
 rtl/psram_arbiter.sv | 154 +++++++++++++++
 tb/tb_psram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// PSRAM arbiter shared types and constants.
// State encoding, data-mask codes and timing defaults.
package psram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        GAP
    } state_t;

    localparam logic [3:0] MASK_WORD = 4'b0011;
    localparam logic [3:0] MASK_LO   = 4'b1011;
    localparam logic [3:0] MASK_HI   = 4'b0111;
    localparam logic [3:0] MASK_NONE = 4'b1111;

    localparam int T_CMD_DEF      = 14;
    localparam int RD_TIMEOUT_DEF = 64;

    // Write data sits in lanes 3:2; an odd byte keeps lane 3 only.
    function automatic logic [3:0] mask_for(
        input logic we,
        input logic bt,
        input logic a0
    );
        if (!we)
            return MASK_NONE;
        if (!bt)
            return MASK_WORD;
        return a0 ? MASK_HI : MASK_LO;
    endfunction

endpackage

// File: rtl/psram_arbiter_rr_arb2.sv
// Two-way round-robin grant for the PSRAM arbiter.
// On a tie the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Tie goes to the port opposite the last grant.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11)
            grant = last ? 2'b01 : 2'b10;
        else
            grant = req;
    end

endmodule

// File: rtl/psram_arbiter.sv
// Two-port arbiter in front of a PSRAM controller user port.
// One command per grant, paced by T_CMD, with read timeout.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int T_CMD      = T_CMD_DEF,
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
    input  logic        clk_out,
    input  logic        rst_n,
    input  logic        init_calib,
    input  logic        req0,
    input  logic        we0,
    input  logic        byte0,
    input  logic [21:0] addr0,
    input  logic [15:0] wdata0,
    output logic        ack0,
    output logic [15:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic        byte1,
    input  logic [21:0] addr1,
    input  logic [15:0] wdata1,
    output logic        ack1,
    output logic [15:0] rdata1,
    output logic        err,
    output logic        cmd,
    output logic        cmd_en,
    output logic [20:0] addr,
    output logic [31:0] wr_data,
    output logic [3:0]  data_mask,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    output logic        busy
);

    localparam logic [5:0] CNT_DONE = 6'(T_CMD - 1);
    localparam logic [5:0] CNT_TO   = 6'(RD_TIMEOUT - 1);

    state_t      state;
    logic [1:0]  gnt;
    logic        last;
    logic        sel;
    logic        lat_we;
    logic        lat_byte;
    logic [21:0] lat_addr;
    logic [15:0] lat_wdata;
    logic [5:0]  cnt;
    logic        got;
    logic        err_pend;
    logic        rd_wait;
    logic        unused_bits;

    assign busy        = (state != IDLE);
    assign rd_wait     = !lat_we && !got;
    assign unused_bits = ^rd_data[15:0];

    rr_arb2 u_arb (
        .req   ({req1, req0}),
        .last  (last),
        .grant (gnt)
    );

    // Transaction sequencer; all controller and requester outputs registered.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            sel       <= 1'b0;
            lat_we    <= 1'b0;
            lat_byte  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            got       <= 1'b0;
            err_pend  <= 1'b0;
            cmd       <= 1'b0;
            cmd_en    <= 1'b0;
            addr      <= '0;
            wr_data   <= '0;
            data_mask <= MASK_NONE;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err       <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            cmd_en    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err       <= 1'b0;
            data_mask <= MASK_NONE;
            unique case (state)
                IDLE: begin
                    if (init_calib && gnt != 2'b00) begin
                        sel       <= gnt[1];
                        last      <= gnt[1];
                        lat_we    <= gnt[1] ? we1 : we0;
                        lat_byte  <= gnt[1] ? byte1 : byte0;
                        lat_addr  <= gnt[1] ? addr1 : addr0;
                        lat_wdata <= gnt[1] ? wdata1 : wdata0;
                        cnt       <= '0;
                        got       <= 1'b0;
                        err_pend  <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmd_en    <= 1'b1;
                    cmd       <= lat_we;
                    addr      <= lat_addr[21:1];
                    wr_data   <= {lat_wdata, 16'h0000};
                    data_mask <= mask_for(lat_we, lat_byte, lat_addr[0]);
                    cnt       <= cnt + 6'd1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt != 6'h3f)
                        cnt <= cnt + 6'd1;
                    if (rd_wait && rd_data_valid) begin
                        got <= 1'b1;
                        if (sel)
                            rdata1 <= rd_data[31:16];
                        else
                            rdata0 <= rd_data[31:16];
                    end
                    if (rd_wait && !rd_data_valid && cnt >= CNT_TO) begin
                        if (sel)
                            rdata1 <= 16'hFFFF;
                        else
                            rdata0 <= 16'hFFFF;
                        err_pend <= 1'b1;
                        state    <= DONE;
                    end else if (cnt >= CNT_DONE && !rd_wait) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    ack0  <= !sel;
                    ack1  <= sel;
                    err   <= err_pend;
                    state <= GAP;
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter.
// Directed vectors; monitor pops expectations on cmd_en and ack.
module tb_psram_arbiter;

    localparam int T_CMD      = 14;
    localparam int RD_TIMEOUT = 64;

    logic        clk_out = 1'b0;
    logic        rst_n;
    logic        init_calib;
    logic        req0, we0, byte0;
    logic [21:0] addr0;
    logic [15:0] wdata0;
    logic        ack0;
    logic [15:0] rdata0;
    logic        req1, we1, byte1;
    logic [21:0] addr1;
    logic [15:0] wdata1;
    logic        ack1;
    logic [15:0] rdata1;
    logic        err, cmd, cmd_en, busy;
    logic [20:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  data_mask;
    logic [31:0] rd_data;
    logic        rd_data_valid;

    typedef struct {
        logic        cmd;
        logic [20:0] addr;
        logic [31:0] wd;
        logic [3:0]  mask;
        int          gap;
    } cmd_exp_t;

    typedef struct {
        logic [1:0]  ack;
        logic        err;
        logic [15:0] r0;
        logic [15:0] r1;
        int          lat;
    } ack_exp_t;

    cmd_exp_t cmd_q[$];
    ack_exp_t ack_q[$];

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int last_cmd = 0;
    bit have_prev = 0;
    int cmd_cnt = 0;

    logic        rd_en = 1'b0;
    int          rd_delay = 5;
    logic [31:0] beat0 = '0;
    logic [31:0] beat1 = '0;

    psram_arbiter #(.T_CMD(T_CMD), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk_out       (clk_out),
        .rst_n         (rst_n),
        .init_calib    (init_calib),
        .req0          (req0),
        .we0           (we0),
        .byte0         (byte0),
        .addr0         (addr0),
        .wdata0        (wdata0),
        .ack0          (ack0),
        .rdata0        (rdata0),
        .req1          (req1),
        .we1           (we1),
        .byte1         (byte1),
        .addr1         (addr1),
        .wdata1        (wdata1),
        .ack1          (ack1),
        .rdata1        (rdata1),
        .err           (err),
        .cmd           (cmd),
        .cmd_en        (cmd_en),
        .addr          (addr),
        .wr_data       (wr_data),
        .data_mask     (data_mask),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .busy          (busy)
    );

    always #5 clk_out = ~clk_out;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push_cmd(input logic c, input logic [20:0] a,
                            input logic [31:0] wd, input logic [3:0] m,
                            input int gap);
        cmd_exp_t e;
        e.cmd = c; e.addr = a; e.wd = wd; e.mask = m; e.gap = gap;
        cmd_q.push_back(e);
    endtask

    task automatic push_ack(input logic [1:0] k, input logic e,
                            input logic [15:0] r0, input logic [15:0] r1,
                            input int lat);
        ack_exp_t x;
        x.ack = k; x.err = e; x.r0 = r0; x.r1 = r1; x.lat = lat;
        ack_q.push_back(x);
    endtask

    // Monitor: compare controller commands and acks against the queues.
    always @(negedge clk_out) begin
        cmd_exp_t ce;
        ack_exp_t ae;
        cyc++;
        if (cmd_en) begin
            cmd_cnt++;
            if (cmd_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_cmd_en: got cmd_en=1 addr=%h, expected none", addr);
            end else begin
                ce = cmd_q.pop_front();
                chk("cmd", 32'(cmd), 32'(ce.cmd));
                chk("addr", 32'(addr), 32'(ce.addr));
                chk("wr_data", wr_data, ce.wd);
                chk("mask", 32'(data_mask), 32'(ce.mask));
                if (ce.gap != 0)
                    chk("cmd_gap", 32'(cyc - last_cmd), 32'(ce.gap));
                else if (have_prev)
                    chk("cmd_min_gap", 32'(cyc - last_cmd >= T_CMD), 32'd1);
            end
            last_cmd = cyc;
            have_prev = 1;
        end
        if (ack0 || ack1) begin
            if (ack_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_ack: got ack1/ack0=%b%b, expected none", ack1, ack0);
            end else begin
                ae = ack_q.pop_front();
                chk("ack_port", 32'({ack1, ack0}), 32'(ae.ack));
                chk("err", 32'(err), 32'(ae.err));
                chk("rdata0", 32'(rdata0), 32'(ae.r0));
                chk("rdata1", 32'(rdata1), 32'(ae.r1));
                chk("ack_latency", 32'(cyc - last_cmd), 32'(ae.lat));
            end
        end
    end

    // Controller read responder: two beats after a programmable delay.
    initial begin
        rd_data_valid = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge clk_out);
            if (cmd_en && !cmd && rd_en) begin
                repeat (rd_delay) @(negedge clk_out);
                rd_data_valid = 1'b1;
                rd_data = beat0;
                @(negedge clk_out);
                rd_data = beat1;
                @(negedge clk_out);
                rd_data_valid = 1'b0;
                rd_data = '0;
            end
        end
    end

    task automatic check_reset();
        chk("rst_cmd_en", 32'(cmd_en), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_mask", 32'(data_mask), 32'hF);
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata0", 32'(rdata0), 32'd0);
        chk("rst_rdata1", 32'(rdata1), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_req(input int p, input logic we, input logic bt,
                           input logic [21:0] a, input logic [15:0] d);
        bit seen = 0;
        @(negedge clk_out);
        if (p == 0) begin
            req0 = 1; we0 = we; byte0 = bt; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1; we1 = we; byte1 = bt; addr1 = a; wdata1 = d;
        end
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_out);
            if (i == 0)
                chk("busy_after_grant", 32'(busy), 32'd1);
            if (i == 3) begin
                if (p == 0) begin addr0 = ~a; wdata0 = ~d; end
                else begin addr1 = ~a; wdata1 = ~d; end
            end
            if ((p == 0 && ack0) || (p == 1 && ack1))
                seen = 1;
        end
        chk("ack_arrived", 32'(seen), 32'd1);
        if (p == 0) req0 = 0; else req1 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int acks;
        bit seen;
        rst_n = 0; init_calib = 0;
        req0 = 0; we0 = 0; byte0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; byte1 = 0; addr1 = '0; wdata1 = '0;
        repeat (3) @(negedge clk_out);
        check_reset();
        rst_n = 1;

        // no calibration: requests must be ignored
        base = cmd_cnt;
        req0 = 1; we0 = 1;
        repeat (30) @(negedge clk_out);
        chk("no_calib_cmd", 32'(cmd_cnt - base), 32'd0);
        chk("no_calib_busy", 32'(busy), 32'd0);
        req0 = 0;
        init_calib = 1;
        @(negedge clk_out);

        // word write
        push_cmd(1, 21'h000080, 32'h12340000, 4'b0011, 0);
        push_ack(2'b01, 0, 16'h0000, 16'h0000, T_CMD);
        run_req(0, 1, 0, 22'h000100, 16'h1234);

        // byte writes odd then even
        push_cmd(1, 21'h000080, 32'h00AB0000, 4'b0111, 0);
        push_ack(2'b01, 0, 16'h0000, 16'h0000, T_CMD);
        run_req(0, 1, 1, 22'h000101, 16'h00AB);
        push_cmd(1, 21'h000080, 32'h00CD0000, 4'b1011, 0);
        push_ack(2'b01, 0, 16'h0000, 16'h0000, T_CMD);
        run_req(0, 1, 1, 22'h000100, 16'h00CD);

        // read on port 1, two beats, second ignored
        rd_en = 1; rd_delay = 5;
        beat0 = 32'hBEEF0000; beat1 = 32'h11110000;
        push_cmd(0, 21'h000100, 32'h00000000, 4'b1111, 0);
        push_ack(2'b10, 0, 16'h0000, 16'hBEEF, T_CMD);
        run_req(1, 0, 0, 22'h000200, 16'h0000);
        chk("rdata1_after_burst", 32'(rdata1), 32'h0000BEEF);

        // both ports held: 0,1,0,1 back to back
        push_cmd(1, 21'h000008, 32'hAAAA0000, 4'b0011, 0);
        push_ack(2'b01, 0, 16'h0000, 16'hBEEF, T_CMD);
        push_cmd(1, 21'h000010, 32'h55550000, 4'b0011, T_CMD + 3);
        push_ack(2'b10, 0, 16'h0000, 16'hBEEF, T_CMD);
        push_cmd(1, 21'h000008, 32'hAAAA0000, 4'b0011, T_CMD + 3);
        push_ack(2'b01, 0, 16'h0000, 16'hBEEF, T_CMD);
        push_cmd(1, 21'h000010, 32'h55550000, 4'b0011, T_CMD + 3);
        push_ack(2'b10, 0, 16'h0000, 16'hBEEF, T_CMD);
        @(negedge clk_out);
        req0 = 1; we0 = 1; byte0 = 0; addr0 = 22'h000010; wdata0 = 16'hAAAA;
        req1 = 1; we1 = 1; byte1 = 0; addr1 = 22'h000020; wdata1 = 16'h5555;
        acks = 0;
        for (int i = 0; i < 300 && acks < 4; i++) begin
            @(negedge clk_out);
            if (ack0 || ack1)
                acks++;
        end
        chk("alt_acks", 32'(acks), 32'd4);
        req0 = 0; req1 = 0;
        repeat (3) @(negedge clk_out);

        // read timeout on port 0
        rd_en = 0;
        push_cmd(0, 21'h000180, 32'h00000000, 4'b1111, 0);
        push_ack(2'b01, 1, 16'hFFFF, 16'hBEEF, RD_TIMEOUT);
        run_req(0, 0, 0, 22'h000300, 16'h0000);

        // reset during WAIT of a read; late beat must be ignored
        rd_en = 1; rd_delay = 8;
        beat0 = 32'hCAFE0000; beat1 = 32'h00000000;
        push_cmd(0, 21'h000200, 32'h00000000, 4'b1111, 0);
        @(negedge clk_out);
        req0 = 1; we0 = 0; byte0 = 0; addr0 = 22'h000400; wdata0 = '0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_out);
            if (cmd_en)
                seen = 1;
        end
        chk("rst_test_cmd_en", 32'(seen), 32'd1);
        repeat (3) @(negedge clk_out);
        rst_n = 0;
        req0 = 0;
        @(negedge clk_out);
        check_reset();
        rst_n = 1;
        repeat (20) @(negedge clk_out);
        chk("post_rst_rdata0", 32'(rdata0), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        push_cmd(1, 21'h000001, 32'h77770000, 4'b0011, 0);
        push_ack(2'b01, 0, 16'h0000, 16'h0000, T_CMD);
        run_req(0, 1, 0, 22'h000002, 16'h7777);

        // calibration lost mid-transaction: finish, then block
        push_cmd(1, 21'h000003, 32'h0F0F0000, 4'b0011, 0);
        push_ack(2'b01, 0, 16'h0000, 16'h0000, T_CMD);
        fork
            run_req(0, 1, 0, 22'h000006, 16'h0F0F);
            begin
                repeat (4) @(negedge clk_out);
                init_calib = 0;
            end
        join
        base = cmd_cnt;
        req0 = 1; we0 = 1; addr0 = 22'h000008;
        repeat (40) @(negedge clk_out);
        chk("calib_block_cmd", 32'(cmd_cnt - base), 32'd0);
        chk("calib_block_busy", 32'(busy), 32'd0);
        req0 = 0;
        repeat (3) @(negedge clk_out);

        chk("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
